// File: rtl/stg1if.sv
// stg1if: instruction fetch stage issuing word reads and buffering {pc, instr} pairs
// in a small FIFO for decode, with taken-branch redirect flushing stale data.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module stg1if #(
    parameter logic [`SIZE_ADDR-1:0] RESET_PC = '0,
    parameter int DEPTH = 2
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    output logic                  ow_imem_req,
    output logic [`SIZE_ADDR-1:0] ow_imem_addr,
    input  logic                  iw_imem_ack,
    input  logic [`SIZE_DATA-1:0] iw_imem_data,
    output logic [`SIZE_ADDR-1:0] ow_pc,
    output logic [`SIZE_DATA-1:0] ow_instr,
    output logic                  ow_valid,
    input  logic                  iw_stall,
    input  logic                  iw_redirect,
    input  logic [`SIZE_ADDR-1:0] iw_redirect_pc
);
    localparam int AW = `SIZE_ADDR;
    localparam int DW = `SIZE_DATA;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    r_fetch_pc, r_pend_pc;
    logic             r_pend, r_stale;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_rd, r_wr;
    logic [AW+DW-1:0] r_mem [DEPTH];
    logic             push, pop, stale_wait;
    logic [CW:0]      occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push       = iw_imem_ack && r_pend && !r_stale && !iw_redirect;
    assign pop        = ow_valid && !iw_stall && !iw_redirect;
    assign stale_wait = r_pend && r_stale && !iw_imem_ack;
    // Occupancy after this edge, counting a stale request that still owes an ack.
    assign occ = {1'b0, r_count} + (CW+1)'(push) - (CW+1)'(pop) + (CW+1)'(stale_wait);

    assign ow_imem_req  = !iw_rst && !iw_redirect && (!r_pend || iw_imem_ack) && (occ < (CW+1)'(DEPTH));
    assign ow_imem_addr = r_fetch_pc;
    assign ow_valid     = r_count != '0;
    assign {ow_pc, ow_instr} = ow_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge iw_clk) begin
        if (push) r_mem[r_wr] <= {r_pend_pc, iw_imem_data};
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_pend     <= 1'b0;
            r_stale    <= 1'b0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
        end else if (iw_redirect) begin
            r_fetch_pc <= iw_redirect_pc;
            r_pend     <= r_pend && !iw_imem_ack;
            r_stale    <= r_pend && !iw_imem_ack;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
        end else begin
            if (ow_imem_req) begin
                r_fetch_pc <= r_fetch_pc + AW'(1);
                r_pend_pc  <= r_fetch_pc;
                r_pend     <= 1'b1;
                r_stale    <= 1'b0;
            end else if (iw_imem_ack) begin
                r_pend <= 1'b0;
            end
            if (push) r_wr <= nxt(r_wr);
            if (pop) r_rd <= nxt(r_rd);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_stg1if.sv
// tb_stg1if: directed table-driven bench for stg1if with a latency-programmable memory model.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_stg1if;
    localparam int AW = `SIZE_ADDR;
    localparam int DW = `SIZE_DATA;

    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    always #5 iw_clk = ~iw_clk;

    logic          req, ack, stall, redir, v;
    logic [AW-1:0] addr, rpc, pc;
    logic [DW-1:0] data, instr;
    logic          b_req, b_ack, b_v;
    logic [AW-1:0] b_addr, b_pc;
    logic [DW-1:0] b_data, b_instr;

    stg1if #(.RESET_PC(16'h0010), .DEPTH(2)) u_dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .ow_imem_req(req), .ow_imem_addr(addr),
        .iw_imem_ack(ack), .iw_imem_data(data),
        .ow_pc(pc), .ow_instr(instr), .ow_valid(v),
        .iw_stall(stall), .iw_redirect(redir), .iw_redirect_pc(rpc)
    );

    stg1if #(.RESET_PC(16'hFFFF), .DEPTH(2)) u_dut_wrap (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .ow_imem_req(b_req), .ow_imem_addr(b_addr),
        .iw_imem_ack(b_ack), .iw_imem_data(b_data),
        .ow_pc(b_pc), .ow_instr(b_instr), .ow_valid(b_v),
        .iw_stall(1'b0), .iw_redirect(1'b0), .iw_redirect_pc(16'h0000)
    );

    function automatic logic [DW-1:0] ins(input logic [AW-1:0] a);
        return DW'(16'hA000) | DW'(a);
    endfunction

    // In-order memory: a request seen at an edge acks lat cycles later.
    int lat = 1;
    int m_cnt = 0, b_cnt = 0;
    logic [AW-1:0] m_addr = '0, b_maddr = '0;
    always @(posedge iw_clk) begin
        if (req) begin
            m_cnt  <= lat;
            m_addr <= addr;
        end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
        if (b_req) begin
            b_cnt   <= 1;
            b_maddr <= b_addr;
        end else if (b_cnt != 0) b_cnt <= b_cnt - 1;
    end
    assign ack    = m_cnt == 1;
    assign data   = ins(m_addr);
    assign b_ack  = b_cnt == 1;
    assign b_data = ins(b_maddr);

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          stall;
        logic          redir;
        logic [AW-1:0] rpc;
        int            lat;
        logic          req;
        logic [AW-1:0] addr;
        logic          v;
        logic [AW-1:0] pc;
    } vec_t;
    vec_t tbl [23];

    task automatic step(input logic s, input logic r, input logic [AW-1:0] p);
        stall = s;
        redir = r;
        rpc   = p;
        @(negedge iw_clk);
    endtask

    task automatic adv();
        @(posedge iw_clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0010, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0011, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0012, 1'b1, 16'h0010};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0013, 1'b1, 16'h0011};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0014, 1'b1, 16'h0012};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0014, 1'b1, 16'h0012};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0014, 1'b1, 16'h0012};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0014, 1'b1, 16'h0012};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0014, 1'b1, 16'h0012};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0015, 1'b1, 16'h0013};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0016, 1'b1, 16'h0014};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0017, 1'b1, 16'h0015};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h0018, 1'b1, 16'h0016};
        tbl[13] = '{1'b0, 1'b1, 16'h0100, 3, 1'b0, 16'h0019, 1'b1, 16'h0017};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 3, 1'b0, 16'h0100, 1'b0, 16'h0000};
        tbl[15] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h0100, 1'b0, 16'h0000};
        tbl[16] = '{1'b0, 1'b0, 16'h0000, 3, 1'b0, 16'h0101, 1'b0, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 3, 1'b0, 16'h0101, 1'b0, 16'h0000};
        tbl[18] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h0101, 1'b0, 16'h0000};
        tbl[19] = '{1'b0, 1'b0, 16'h0000, 3, 1'b0, 16'h0102, 1'b1, 16'h0100};
        tbl[20] = '{1'b0, 1'b0, 16'h0000, 3, 1'b0, 16'h0102, 1'b0, 16'h0000};
        tbl[21] = '{1'b0, 1'b0, 16'h0000, 3, 1'b1, 16'h0102, 1'b0, 16'h0000};
        tbl[22] = '{1'b1, 1'b0, 16'h0000, 3, 1'b0, 16'h0103, 1'b1, 16'h0101};

        stall = 1'b0;
        redir = 1'b0;
        rpc   = '0;
        repeat (3) @(posedge iw_clk);
        @(negedge iw_clk);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 16'h0010);
        chk("rst_valid", v, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_wrap_addr", b_addr, 16'hFFFF);
        @(posedge iw_clk);
        #1;
        iw_rst = 1'b0;

        // Steady fetch, stall hold, then redirect over a 3-cycle memory.
        for (int i = 0; i < 23; i++) begin
            lat = tbl[i].lat;
            step(tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("c%0d_req", i + 1), req, tbl[i].req);
            chk($sformatf("c%0d_addr", i + 1), addr, tbl[i].addr);
            chk($sformatf("c%0d_valid", i + 1), v, tbl[i].v);
            chk($sformatf("c%0d_pc", i + 1), pc, tbl[i].pc);
            chk($sformatf("c%0d_instr", i + 1), instr, tbl[i].v ? ins(tbl[i].pc) : '0);
            if (i < 5) chk($sformatf("c%0d_wrap_addr", i + 1), b_addr, AW'(16'hFFFF + i));
            if (i >= 2 && i < 5) begin
                chk($sformatf("c%0d_wrap_pc", i + 1), b_pc, AW'(16'hFFFF + i - 2));
                chk($sformatf("c%0d_wrap_instr", i + 1), b_instr, ins(AW'(16'hFFFF + i - 2)));
                chk($sformatf("c%0d_wrap_valid", i + 1), b_v, 1);
            end
            adv();
        end

        // Redirect in the ack cycle while stalled with a valid head.
        step(1'b1, 1'b0, 16'h0000);
        chk("c24_valid", v, 1);
        chk("c24_pc", pc, 16'h0101);
        chk("c24_req", req, 0);
        adv();
        lat = 1;
        step(1'b1, 1'b1, 16'h0200);
        chk("c25_ack", ack, 1);
        chk("c25_pc", pc, 16'h0101);
        chk("c25_req", req, 0);
        adv();
        step(1'b0, 1'b0, 16'h0000);
        chk("c26_valid", v, 0);
        chk("c26_req", req, 1);
        chk("c26_addr", addr, 16'h0200);
        adv();
        lat = 3;
        step(1'b0, 1'b0, 16'h0000);
        chk("c27_valid", v, 0);
        chk("c27_addr", addr, 16'h0201);
        chk("c27_req", req, 1);
        adv();
        step(1'b1, 1'b0, 16'h0000);
        chk("c28_pc", pc, 16'h0200);
        chk("c28_instr", instr, ins(16'h0200));
        chk("c28_req", req, 0);
        adv();

        // Asynchronous reset with an entry buffered and a request in flight.
        step(1'b1, 1'b0, 16'h0000);
        chk("c29_valid", v, 1);
        #2;
        iw_rst = 1'b1;
        #1;
        chk("async_valid", v, 0);
        chk("async_pc", pc, 0);
        chk("async_instr", instr, 0);
        chk("async_req", req, 0);
        chk("async_addr", addr, 16'h0010);
        @(posedge iw_clk);
        #1;
        iw_rst = 1'b0;
        lat = 1;
        step(1'b0, 1'b0, 16'h0000);
        chk("c30_late_ack", ack, 1);
        chk("c30_valid", v, 0);
        chk("c30_req", req, 1);
        chk("c30_addr", addr, 16'h0010);
        adv();
        step(1'b0, 1'b0, 16'h0000);
        chk("c31_valid", v, 0);
        chk("c31_addr", addr, 16'h0011);
        adv();
        step(1'b0, 1'b0, 16'h0000);
        chk("c32_valid", v, 1);
        chk("c32_pc", pc, 16'h0010);
        chk("c32_instr", instr, ins(16'h0010));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
